// File: rtl/sha256_block_feeder_if.sv
// Bundles the feeder's control, memory-read and hasher-handshake signals.
// slave is the feeder's view; master is the view of whatever drives the feeder.
interface sha256_block_feeder_if;
    logic         start;
    logic [15:0]  message_addr;
    logic [15:0]  mem_addr;
    logic         mem_rd;
    logic [31:0]  mem_read_data;
    logic         blk_start;
    logic [511:0] blk_data;
    logic [255:0] blk_h_in;
    logic [255:0] blk_h_out;
    logic         blk_done;
    logic         busy;
    logic         done;
    logic [255:0] digest;

    modport slave (
        input  start, message_addr, mem_read_data, blk_h_out, blk_done,
        output mem_addr, mem_rd, blk_start, blk_data, blk_h_in, busy, done, digest
    );

    modport master (
        output start, message_addr, mem_read_data, blk_h_out, blk_done,
        input  mem_addr, mem_rd, blk_start, blk_data, blk_h_in, busy, done, digest
    );
endinterface

// File: rtl/sha256_block_feeder.sv
// Fetches a fixed-length message from memory, pads it into SHA-256 blocks and
// drives a single-block hasher, chaining the intermediate hash between blocks.
module sha256_block_feeder #(
    parameter int NUM_OF_WORDS = 20
) (
    input logic                 clk,
    input logic                 reset,
    sha256_block_feeder_if.slave bus
);
    localparam int           NUM_BLOCKS = (NUM_OF_WORDS * 32 + 65 + 511) / 512;
    localparam logic [63:0]  MSG_BITS   = 64'(NUM_OF_WORDS) * 64'd32;
    localparam logic [31:0]  N_WORDS    = 32'(NUM_OF_WORDS);
    localparam logic [15:0]  LAST_BLK   = 16'(NUM_BLOCKS - 1);
    localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                   32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    typedef enum logic [2:0] {IDLE, FETCH, HASH, WAIT, NEXT, DONE} state_t;

    state_t       state_q, state_d;
    logic [15:0]  b_q, b_d;
    logic [4:0]   c_q, c_d;
    logic [15:0]  base_q, base_d;
    logic [15:0]  mem_addr_q, mem_addr_d;
    logic         mem_rd_q, mem_rd_d;
    logic         blk_start_q, blk_start_d;
    logic [511:0] blk_data_q, blk_data_d;
    logic [255:0] blk_h_in_q, blk_h_in_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic [255:0] digest_q, digest_d;

    logic [31:0]  g_wr;
    logic [31:0]  g_rd;
    logic [31:0]  g_next_blk;
    logic         last_blk;
    logic [31:0]  word_val;

    // g_wr is the global index of the word being written this cycle (valid for c >= 1)
    assign g_wr       = {12'd0, b_q, 4'd0} + {27'd0, c_q} - 32'd1;
    assign g_rd       = {12'd0, b_q, 4'd0} + {27'd0, c_q} + 32'd1;
    assign g_next_blk = {12'd0, b_q + 16'd1, 4'd0};
    assign last_blk   = (b_q == LAST_BLK);

    always_comb begin
        word_val = 32'd0;
        if (g_wr < N_WORDS)
            word_val = bus.mem_read_data;
        else if (g_wr == N_WORDS)
            word_val = 32'h8000_0000;
        else if (last_blk && c_q == 5'd15)
            word_val = MSG_BITS[63:32];
        else if (last_blk && c_q == 5'd16)
            word_val = MSG_BITS[31:0];
    end

    always_comb begin
        state_d     = state_q;
        b_d         = b_q;
        c_d         = c_q;
        base_d      = base_q;
        mem_addr_d  = mem_addr_q;
        mem_rd_d    = 1'b0;
        blk_start_d = 1'b0;
        blk_data_d  = blk_data_q;
        blk_h_in_d  = blk_h_in_q;
        done_d      = 1'b0;
        digest_d    = digest_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    base_d     = bus.message_addr;
                    blk_h_in_d = IV;
                    b_d        = 16'd0;
                    c_d        = 5'd0;
                    mem_addr_d = bus.message_addr;
                    mem_rd_d   = 1'b1;
                    state_d    = FETCH;
                end
            end
            FETCH: begin
                // Words shift in from the bottom, so W0 ends up in the top slot after 16 writes
                if (c_q != 5'd0)
                    blk_data_d = {blk_data_q[479:0], word_val};
                if (c_q < 5'd15) begin
                    mem_addr_d = mem_addr_q + 16'd1;
                    mem_rd_d   = (g_rd < N_WORDS);
                end
                if (c_q == 5'd16) begin
                    blk_start_d = 1'b1;
                    state_d     = HASH;
                end else begin
                    c_d = c_q + 5'd1;
                end
            end
            HASH: state_d = WAIT;
            WAIT: begin
                if (bus.blk_done) begin
                    blk_h_in_d = bus.blk_h_out;
                    state_d    = NEXT;
                end
            end
            NEXT: begin
                if (last_blk) begin
                    digest_d = blk_h_in_q;
                    done_d   = 1'b1;
                    state_d  = DONE;
                end else begin
                    b_d        = b_q + 16'd1;
                    c_d        = 5'd0;
                    mem_addr_d = base_q + {b_q[11:0] + 12'd1, 4'd0};
                    mem_rd_d   = (g_next_blk < N_WORDS);
                    state_d    = FETCH;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            b_q         <= '0;
            c_q         <= '0;
            base_q      <= '0;
            mem_addr_q  <= '0;
            mem_rd_q    <= 1'b0;
            blk_start_q <= 1'b0;
            blk_data_q  <= '0;
            blk_h_in_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            digest_q    <= '0;
        end else begin
            state_q     <= state_d;
            b_q         <= b_d;
            c_q         <= c_d;
            base_q      <= base_d;
            mem_addr_q  <= mem_addr_d;
            mem_rd_q    <= mem_rd_d;
            blk_start_q <= blk_start_d;
            blk_data_q  <= blk_data_d;
            blk_h_in_q  <= blk_h_in_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            digest_q    <= digest_d;
        end
    end

    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_rd    = mem_rd_q;
    assign bus.blk_start = blk_start_q;
    assign bus.blk_data  = blk_data_q;
    assign bus.blk_h_in  = blk_h_in_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.digest    = digest_q;
endmodule

// File: tb/tb_sha256_block_feeder.sv
// Drives three feeder instances (20, 13 and 14 words) from one memory model and
// an increment-by-one hasher stub, checking blocks against a padded-message model.
module tb_sha256_block_feeder;
    localparam int NW [3] = '{20, 13, 14};
    localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                   32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset = 1'b1;
    logic [1:0]   sel = 2'd0;
    logic         start_r = 1'b0;
    logic [15:0]  message_addr = 16'd0;
    logic [31:0]  mem [65536];

    logic [2:0][15:0]  mem_addr_a;
    logic [2:0]        mem_rd_a, blk_start_a, busy_a, done_a;
    logic [2:0][511:0] blk_data_a;
    logic [2:0][255:0] blk_h_in_a, digest_a;

    logic         stub_done = 1'b0;
    logic         stub_busy = 1'b0;
    logic [255:0] stub_hout = '0;
    logic [255:0] stub_hcap = '0;
    int           stub_delay = 5;
    int           stub_cnt = 0;

    int tests = 0;
    int errors = 0;

    logic [511:0] blk_log [$];
    logic [255:0] hin_log [$];
    logic [15:0]  rd_log [$];
    logic [31:0]  exp_words [$];

    for (genvar i = 0; i < 3; i++) begin : g_dut
        sha256_block_feeder_if bus_i ();
        logic [31:0] rd_q;
        always @(posedge clk) rd_q <= mem[bus_i.mem_addr];
        assign bus_i.start         = start_r && (sel == 2'(i));
        assign bus_i.message_addr  = message_addr;
        assign bus_i.mem_read_data = rd_q;
        assign bus_i.blk_h_out     = stub_hout;
        assign bus_i.blk_done      = stub_done && (sel == 2'(i));
        assign mem_addr_a[i]  = bus_i.mem_addr;
        assign mem_rd_a[i]    = bus_i.mem_rd;
        assign blk_start_a[i] = bus_i.blk_start;
        assign blk_data_a[i]  = bus_i.blk_data;
        assign blk_h_in_a[i]  = bus_i.blk_h_in;
        assign busy_a[i]      = bus_i.busy;
        assign done_a[i]      = bus_i.done;
        assign digest_a[i]    = bus_i.digest;
        sha256_block_feeder #(.NUM_OF_WORDS(NW[i])) dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus_i)
        );
    end

    logic [15:0]  mem_addr_s;
    logic         mem_rd_s, blk_start_s, busy_s, done_s;
    logic [511:0] blk_data_s;
    logic [255:0] blk_h_in_s, digest_s;
    assign mem_addr_s  = mem_addr_a[sel];
    assign mem_rd_s    = mem_rd_a[sel];
    assign blk_start_s = blk_start_a[sel];
    assign busy_s      = busy_a[sel];
    assign done_s      = done_a[sel];
    assign blk_data_s  = blk_data_a[sel];
    assign blk_h_in_s  = blk_h_in_a[sel];
    assign digest_s    = digest_a[sel];

    function automatic logic [255:0] add_each(input logic [255:0] h, input int k);
        logic [255:0] r;
        for (int j = 0; j < 8; j++) r[j*32 +: 32] = h[j*32 +: 32] + 32'(k);
        return r;
    endfunction

    // Hasher stub: answers each blk_start with blk_h_in+1 per word after stub_delay cycles
    always @(posedge clk) begin
        stub_done <= 1'b0;
        if (reset) begin
            stub_busy <= 1'b0;
        end else if (stub_busy) begin
            if (stub_cnt >= stub_delay) begin
                stub_done <= 1'b1;
                stub_hout <= add_each(stub_hcap, 1);
                stub_busy <= 1'b0;
            end
            stub_cnt <= stub_cnt + 1;
        end else if (blk_start_s) begin
            stub_busy <= 1'b1;
            stub_cnt  <= 1;
            stub_hcap <= blk_h_in_s;
            blk_log.push_back(blk_data_s);
            hin_log.push_back(blk_h_in_s);
        end
    end

    always @(posedge clk) if (!reset && mem_rd_s) rd_log.push_back(mem_addr_s);

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        tests++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Standard SHA-256 padding of the message as a flat word list
    function automatic void build_expected(input int n, input logic [15:0] base);
        exp_words.delete();
        for (int k = 0; k < n; k++) exp_words.push_back(mem[base + 16'(k)]);
        exp_words.push_back(32'h8000_0000);
        while (exp_words.size() % 16 != 14) exp_words.push_back(32'd0);
        exp_words.push_back(32'd0);
        exp_words.push_back(32'(n * 32));
    endfunction

    function automatic logic [511:0] exp_block(input int j);
        logic [511:0] r = '0;
        for (int w = 0; w < 16; w++) r = {r[479:0], exp_words[16*j + w]};
        return r;
    endfunction

    function automatic logic [31:0] word_of(input int blk, input int w);
        logic [511:0] b;
        if (blk >= blk_log.size()) return 'x;
        b = blk_log[blk];
        return b[511 - 32*w -: 32];
    endfunction

    task automatic check_reset_state(input string tag);
        check_output({tag, "_ctl"}, {mem_addr_s, mem_rd_s, blk_start_s, busy_s, done_s}, '0);
        check_output({tag, "_blk_data"}, blk_data_s, '0);
        check_output({tag, "_blk_h_in"}, blk_h_in_s, '0);
        check_output({tag, "_digest"}, digest_s, '0);
    endtask

    task automatic run_message(input logic [1:0] d, input logic [15:0] base, input int hold,
                               input bit poke_start);
        int n, nb, bad;
        bit seen;
        logic [511:0] snap;
        n = NW[d];
        build_expected(n, base);
        nb = exp_words.size() / 16;
        sel = d;
        stub_delay = hold;
        blk_log.delete();
        hin_log.delete();
        rd_log.delete();
        @(negedge clk);
        message_addr = base;
        start_r = 1'b1;
        @(negedge clk);
        start_r = 1'b0;
        message_addr = 16'h5a5a;
        if (poke_start) begin
            seen = 0;
            for (int cyc = 0; cyc < 200 && !seen; cyc++) begin
                @(negedge clk);
                if (blk_log.size() != 0) seen = 1;
            end
            check_output("reach_wait", 512'(seen), 512'd1);
            repeat (2) @(negedge clk);
            snap = blk_data_s;
            message_addr = 16'h1234;
            start_r = 1'b1;
            @(negedge clk);
            start_r = 1'b0;
            repeat (60) @(negedge clk);
            check_output("wait_blk_data_stable", blk_data_s, snap);
            check_output("wait_busy", 512'(busy_s), 512'd1);
        end
        seen = 0;
        for (int cyc = 0; cyc < 3000 && !seen; cyc++) begin
            @(negedge clk);
            if (done_s) seen = 1;
        end
        check_output("done_seen", 512'(seen), 512'd1);
        if (seen) begin
            check_output("digest", digest_s, add_each(IV, nb));
            if (poke_start) begin
                message_addr = 16'h4321;
                start_r = 1'b1;
            end
            @(negedge clk);
            start_r = 1'b0;
            check_output("done_single_cycle", 512'(done_s), 512'd0);
            check_output("idle_after_done", 512'(busy_s), 512'd0);
        end
        check_output("block_count", 512'(blk_log.size()), 512'(nb));
        for (int j = 0; j < nb; j++) begin
            check_output($sformatf("blk%0d_data", j),
                         (j < blk_log.size()) ? blk_log[j] : 'x, exp_block(j));
            check_output($sformatf("blk%0d_h_in", j),
                         (j < hin_log.size()) ? {256'd0, hin_log[j]} : 'x, {256'd0, add_each(IV, j)});
        end
        check_output("read_count", 512'(rd_log.size()), 512'(n));
        bad = 0;
        for (int k = 0; k < rd_log.size() && k < n; k++)
            if (rd_log[k] !== base + 16'(k)) bad++;
        check_output("read_addrs", 512'(bad), 512'd0);
    endtask

    initial begin
        logic [15:0] rbase;
        bit seen;
        for (int k = 0; k < 65536; k++) mem[k] = 32'(k + 1);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int d = 0; d < 3; d++) begin
            sel = 2'(d);
            #1;
            check_reset_state($sformatf("reset_dut%0d", d));
        end

        // Twenty words from base 0: two blocks, padding lands in block 1
        run_message(2'd0, 16'h0000, 5, 0);
        check_output("n20_b0_w0", 512'(word_of(0, 0)), 512'd1);
        check_output("n20_b0_w15", 512'(word_of(0, 15)), 512'd16);
        check_output("n20_b1_w3", 512'(word_of(1, 3)), 512'd20);
        check_output("n20_b1_w4", 512'(word_of(1, 4)), 512'h8000_0000);
        check_output("n20_b1_w15", 512'(word_of(1, 15)), 512'h280);
        check_output("n20_digest", digest_s, add_each(IV, 2));

        // Thirteen words at 0x0100: single block
        run_message(2'd1, 16'h0100, 5, 0);
        check_output("n13_w13", 512'(word_of(0, 13)), 512'h8000_0000);
        check_output("n13_w15", 512'(word_of(0, 15)), 512'h1A0);
        check_output("n13_h_in", (hin_log.size() > 0) ? {256'd0, hin_log[0]} : 'x, {256'd0, IV});

        // Fourteen words: padding bit fills W14 of block 0, length gets its own block
        run_message(2'd2, 16'h0000, 5, 0);
        check_output("n14_b0_w14", 512'(word_of(0, 14)), 512'h8000_0000);
        check_output("n14_b0_w15", 512'(word_of(0, 15)), 512'd0);
        check_output("n14_b1", (blk_log.size() > 1) ? blk_log[1] : 'x, {480'd0, 32'h1C0});

        for (int k = 0; k < 65536; k++) mem[k] = $urandom;
        run_message(2'd0, 16'hFFF6, 3, 0);
        for (int r = 0; r < 3; r++) begin
            run_message(2'(r), 16'($urandom), $urandom_range(1, 12), 0);
        end

        // start during WAIT and DONE, with the hasher holding off for 100 cycles
        run_message(2'd0, 16'($urandom), 100, 1);

        // Abort during block 1 fetch, then rerun the same message cleanly
        rbase = 16'($urandom);
        sel = 2'd0;
        stub_delay = 5;
        @(negedge clk);
        message_addr = rbase;
        start_r = 1'b1;
        @(negedge clk);
        start_r = 1'b0;
        seen = 0;
        for (int cyc = 0; cyc < 300 && !seen; cyc++) begin
            @(negedge clk);
            if (mem_rd_s && mem_addr_s == rbase + 16'd16) seen = 1;
        end
        check_output("reach_block1_fetch", 512'(seen), 512'd1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset_state("abort");
        run_message(2'd0, rbase, 5, 0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
